// File: rtl/image_store_pkg.sv
// Shared types and helpers for the image store burst master.
package image_store_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_SOP,
    ST_STREAM,
    ST_DRAIN,
    ST_NEXT
  } state_t;

  function automatic logic [31:0] bytes_per_word(input int data_width);
    return 32'(data_width / 8);
  endfunction

endpackage

// File: rtl/image_store_burst_fifo.sv
// Single-clock show-ahead FIFO: rd_data always presents the head word.
module image_store_burst_fifo #(
  parameter int DATA_WIDTH     = 64,
  parameter int FIFO_DEPTH_LOG = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    pop,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic [FIFO_DEPTH_LOG:0] count,
  output logic                    full,
  output logic                    empty
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG;
  localparam int CNT_W = FIFO_DEPTH_LOG + 1;

  logic [DATA_WIDTH-1:0]     mem [DEPTH];
  logic [FIFO_DEPTH_LOG-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG-1:0] rd_ptr;
  logic                      do_push;
  logic                      do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage carries no reset; only pointers and occupancy are control state.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + FIFO_DEPTH_LOG'(1);
      if (do_pop)  rd_ptr <= rd_ptr + FIFO_DEPTH_LOG'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/image_store_burst_master.sv
// Avalon-ST frame capture into a ring of memory buffers via an Avalon-MM burst master.
module image_store_burst_master
  import image_store_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int FIFO_DEPTH_LOG = 8,
  parameter int BURST_LEN_LOG  = 4,
  parameter int BUF_CNT_W      = 3,
  parameter int FRAME_CNT_W    = 8,
  parameter int WORD_CNT_W     = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_WIDTH-1:0]  din_data,
  input  logic                   din_valid,
  output logic                   din_ready,
  input  logic                   din_startofpacket,
  input  logic                   din_endofpacket,
  output logic [31:0]            avm_address,
  output logic                   avm_write,
  output logic [DATA_WIDTH-1:0]  avm_writedata,
  output logic [BURST_LEN_LOG:0] avm_burstcount,
  input  logic                   avm_waitrequest,
  input  logic                   sig_en,
  input  logic                   sig_stop,
  input  logic [31:0]            sig_address,
  input  logic [31:0]            sig_stride,
  input  logic [BUF_CNT_W-1:0]   sig_buf_cnt,
  input  logic [FRAME_CNT_W-1:0] sig_frame_cnt,
  output logic                   sts_busy,
  output logic                   sts_frame_done,
  output logic [BUF_CNT_W-1:0]   sts_buf_idx,
  output logic [WORD_CNT_W-1:0]  sts_frame_words
);

  localparam int          BURST_LEN  = 1 << BURST_LEN_LOG;
  localparam int          BC_W       = BURST_LEN_LOG + 1;
  localparam int          CNT_W      = FIFO_DEPTH_LOG + 1;
  localparam logic [31:0] WORD_BYTES = bytes_per_word(DATA_WIDTH);

  state_t                 state;
  state_t                 state_nxt;
  logic [31:0]            base;
  logic [31:0]            stride;
  logic [31:0]            buf_base;
  logic [31:0]            frame_offset;
  logic [31:0]            burst_bytes;
  logic [BUF_CNT_W-1:0]   buf_cnt;
  logic [BUF_CNT_W-1:0]   buf_idx;
  logic [FRAME_CNT_W-1:0] frames_left;
  logic                   continuous;
  logic                   stop_pending;
  logic                   last_frame;
  logic [WORD_CNT_W-1:0]  word_cnt;
  logic                   push;
  logic                   sop_take;
  logic                   drain_done;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CNT_W-1:0]       fifo_count;
  logic                   beat_ok;
  logic                   burst_start;
  logic                   burst_ready;
  logic [BC_W-1:0]        burst_size;
  logic [BC_W-1:0]        beats_left;

  image_store_burst_fifo #(
    .DATA_WIDTH     (DATA_WIDTH),
    .FIFO_DEPTH_LOG (FIFO_DEPTH_LOG)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (din_data),
    .pop     (beat_ok),
    .rd_data (avm_writedata),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign sts_busy    = (state != ST_IDLE);
  assign last_frame  = !continuous && (frames_left == FRAME_CNT_W'(1));
  assign beat_ok     = avm_write & ~avm_waitrequest;
  assign burst_ready = (fifo_count >= CNT_W'(BURST_LEN));
  assign burst_start = !avm_write && (burst_ready || (state == ST_DRAIN && !fifo_empty));
  assign burst_size  = burst_ready ? BC_W'(BURST_LEN) : fifo_count[BC_W-1:0];
  assign burst_bytes = 32'(avm_burstcount) * WORD_BYTES;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    din_ready  = 1'b0;
    push       = 1'b0;
    sop_take   = 1'b0;
    drain_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sig_en) state_nxt = ST_WAIT_SOP;
      end
      ST_WAIT_SOP: begin
        din_ready = 1'b1;
        if (sig_stop) begin
          state_nxt = ST_IDLE;
        end else if (din_valid && din_startofpacket) begin
          sop_take  = 1'b1;
          push      = 1'b1;
          state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: begin
        din_ready = ~fifo_full;
        push      = din_valid & ~fifo_full;
        if (push && din_endofpacket) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_empty && !avm_write) begin
          drain_done = 1'b1;
          state_nxt  = ST_NEXT;
        end
      end
      ST_NEXT: begin
        state_nxt = (last_frame || stop_pending || sig_stop) ? ST_IDLE : ST_WAIT_SOP;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Ring geometry is plain data; the buffer base product is formed once per frame.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && sig_en) begin
      base   <= sig_address;
      stride <= sig_stride;
    end
    if (sop_take) buf_base <= base + 32'(buf_idx) * stride;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_cnt      <= BUF_CNT_W'(1);
      buf_idx      <= '0;
      frames_left  <= '0;
      continuous   <= 1'b0;
      stop_pending <= 1'b0;
      word_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sig_en) begin
            buf_cnt      <= (sig_buf_cnt == '0) ? BUF_CNT_W'(1) : sig_buf_cnt;
            frames_left  <= sig_frame_cnt;
            continuous   <= (sig_frame_cnt == '0);
            buf_idx      <= '0;
            stop_pending <= 1'b0;
          end
        end
        ST_WAIT_SOP: begin
          if (sop_take) word_cnt <= WORD_CNT_W'(1);
        end
        ST_STREAM: begin
          if (push && word_cnt != '1) word_cnt <= word_cnt + WORD_CNT_W'(1);
          if (sig_stop) stop_pending <= 1'b1;
        end
        ST_DRAIN: begin
          if (sig_stop) stop_pending <= 1'b1;
        end
        ST_NEXT: begin
          buf_idx <= (buf_idx == buf_cnt - BUF_CNT_W'(1)) ? '0 : buf_idx + BUF_CNT_W'(1);
          if (!continuous) frames_left <= frames_left - FRAME_CNT_W'(1);
          if (state_nxt == ST_IDLE) stop_pending <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Burst engine: address and length are frozen at burst start and held until the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avm_write      <= 1'b0;
      avm_address    <= '0;
      avm_burstcount <= '0;
      beats_left     <= '0;
      frame_offset   <= '0;
    end else begin
      if (sop_take) frame_offset <= '0;
      if (burst_start) begin
        avm_write      <= 1'b1;
        avm_address    <= buf_base + frame_offset;
        avm_burstcount <= burst_size;
        beats_left     <= burst_size;
      end else if (beat_ok) begin
        beats_left <= beats_left - BC_W'(1);
        if (beats_left == BC_W'(1)) begin
          avm_write    <= 1'b0;
          frame_offset <= frame_offset + burst_bytes;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sts_frame_done  <= 1'b0;
      sts_buf_idx     <= '0;
      sts_frame_words <= '0;
    end else begin
      sts_frame_done <= drain_done;
      if (drain_done) begin
        sts_buf_idx     <= buf_idx;
        sts_frame_words <= word_cnt;
      end
    end
  end

endmodule

// File: tb/tb_image_store_burst_master.sv
// Directed bench for image_store_burst_master with a passive Avalon-MM write monitor.
module tb_image_store_burst_master;

  localparam int DW  = 64;
  localparam int BLL = 4;
  localparam int BCW = 3;
  localparam int FCW = 8;
  localparam int WCW = 24;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [DW-1:0]  din_data = '0;
  logic           din_valid = 1'b0;
  logic           din_ready;
  logic           din_startofpacket = 1'b0;
  logic           din_endofpacket = 1'b0;
  logic [31:0]    avm_address;
  logic           avm_write;
  logic [DW-1:0]  avm_writedata;
  logic [BLL:0]   avm_burstcount;
  logic           avm_waitrequest;
  logic           sig_en = 1'b0;
  logic           sig_stop = 1'b0;
  logic [31:0]    sig_address = '0;
  logic [31:0]    sig_stride = '0;
  logic [BCW-1:0] sig_buf_cnt = '0;
  logic [FCW-1:0] sig_frame_cnt = '0;
  logic           sts_busy;
  logic           sts_frame_done;
  logic [BCW-1:0] sts_buf_idx;
  logic [WCW-1:0] sts_frame_words;

  image_store_burst_master #(
    .DATA_WIDTH(DW), .FIFO_DEPTH_LOG(8), .BURST_LEN_LOG(BLL),
    .BUF_CNT_W(BCW), .FRAME_CNT_W(FCW), .WORD_CNT_W(WCW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .din_data(din_data), .din_valid(din_valid), .din_ready(din_ready),
    .din_startofpacket(din_startofpacket), .din_endofpacket(din_endofpacket),
    .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_burstcount(avm_burstcount), .avm_waitrequest(avm_waitrequest),
    .sig_en(sig_en), .sig_stop(sig_stop), .sig_address(sig_address), .sig_stride(sig_stride),
    .sig_buf_cnt(sig_buf_cnt), .sig_frame_cnt(sig_frame_cnt),
    .sts_busy(sts_busy), .sts_frame_done(sts_frame_done),
    .sts_buf_idx(sts_buf_idx), .sts_frame_words(sts_frame_words)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  bit rand_wait = 1'b0;

  logic [31:0]    wr_addr_q[$];
  logic [DW-1:0]  wr_data_q[$];
  logic [31:0]    b_addr_q[$];
  logic [BLL:0]   b_bc_q[$];
  logic [BCW-1:0] d_idx_q[$];
  logic [WCW-1:0] d_words_q[$];
  int             beat = 0;
  logic           prev_w = 1'b0;
  logic [31:0]    lat_addr = '0;
  logic [BLL:0]   lat_bc = '0;
  int             stable_err = 0;

  initial begin
    avm_waitrequest = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      avm_waitrequest = rand_wait ? ($urandom_range(0, 1) == 1) : 1'b0;
    end
  end

  // Sampled mid-cycle: each observation is what the next rising edge will transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      beat   <= 0;
      prev_w <= 1'b0;
    end else begin
      prev_w <= avm_write;
      if (sts_frame_done) begin
        d_idx_q.push_back(sts_buf_idx);
        d_words_q.push_back(sts_frame_words);
      end
      if (avm_write) begin
        if (!prev_w) begin
          lat_addr <= avm_address;
          lat_bc   <= avm_burstcount;
          b_addr_q.push_back(avm_address);
          b_bc_q.push_back(avm_burstcount);
        end else if (avm_address !== lat_addr || avm_burstcount !== lat_bc) begin
          stable_err <= stable_err + 1;
        end
        if (!avm_waitrequest) begin
          wr_addr_q.push_back(avm_address + 32'(beat) * 32'd8);
          wr_data_q.push_back(avm_writedata);
          beat <= (beat + 1 == int'(avm_burstcount)) ? 0 : beat + 1;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] baddr(input int k);
    return (k < b_addr_q.size()) ? b_addr_q[k] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [BLL:0] bbc(input int k);
    return (k < b_bc_q.size()) ? b_bc_q[k] : '1;
  endfunction

  function automatic logic [BCW-1:0] didx(input int k);
    return (k < d_idx_q.size()) ? d_idx_q[k] : '1;
  endfunction

  function automatic logic [WCW-1:0] dwords(input int k);
    return (k < d_words_q.size()) ? d_words_q[k] : '1;
  endfunction

  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete();
    b_addr_q.delete();  b_bc_q.delete();
    d_idx_q.delete();   d_words_q.delete();
  endtask

  task automatic start_run(input logic [31:0] a, input logic [31:0] s,
                           input logic [BCW-1:0] nb, input logic [FCW-1:0] nf);
    sig_address = a; sig_stride = s; sig_buf_cnt = nb; sig_frame_cnt = nf;
    sig_en = 1'b1;
    @(posedge clk); #1;
    sig_en = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [31:0] tag, input bit bubbles,
                            input int stop_at, input bit with_eop);
    int i = 0;
    int guard = 0;
    bit stop_sent = 1'b0;
    while (i < n && guard < 5000) begin
      if (bubbles && $urandom_range(0, 2) == 0) begin
        din_valid = 1'b0;
      end else begin
        din_valid         = 1'b1;
        din_data          = {tag, 32'(i)};
        din_startofpacket = (i == 0);
        din_endofpacket   = with_eop && (i == n - 1);
      end
      sig_stop = (i == stop_at) && !stop_sent;
      if (sig_stop) stop_sent = 1'b1;
      @(negedge clk);
      if (din_valid && din_ready) i++;
      @(posedge clk); #1;
      guard++;
    end
    din_valid = 1'b0; din_startofpacket = 1'b0; din_endofpacket = 1'b0; sig_stop = 1'b0;
    chk($sformatf("send_%0h_accepted", tag), 64'(i), 64'(n));
  endtask

  task automatic wait_idle(input string tag);
    int g = 0;
    while (sts_busy && g < 20000) begin
      @(posedge clk); #1;
      g++;
    end
    chk(tag, 64'(sts_busy), 64'd0);
  endtask

  task automatic check_frame(input string tag, input int q0, input int n,
                             input logic [31:0] base, input logic [31:0] dtag);
    int errs = 0;
    for (int k = 0; k < n; k++) begin
      if (q0 + k >= wr_addr_q.size()) errs++;
      else if (wr_addr_q[q0 + k] !== base + 32'(k) * 32'd8 ||
               wr_data_q[q0 + k] !== {dtag, 32'(k)}) errs++;
    end
    chk(tag, 64'(errs), 64'd0);
  endtask

  initial begin
    int g;
    bit rdy_all;
    bit rdy_any;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_avm_write", 64'(avm_write), 64'd0);
    chk("rst_burstcount", 64'(avm_burstcount), 64'd0);
    chk("rst_address", 64'(avm_address), 64'd0);
    chk("rst_busy", 64'(sts_busy), 64'd0);
    chk("rst_frame_done", 64'(sts_frame_done), 64'd0);
    chk("rst_buf_idx", 64'(sts_buf_idx), 64'd0);
    chk("rst_frame_words", 64'(sts_frame_words), 64'd0);
    chk("rst_din_ready", 64'(din_ready), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single 40-word frame: bursts 16/16/8
    start_run(32'h1000_0000, 32'h0010_0000, 3'd1, 8'd1);
    chk("t1_busy", 64'(sts_busy), 64'd1);
    chk("t1_ready_wait_sop", 64'(din_ready), 64'd1);
    send_frame(40, 32'hA1, 1'b0, -1, 1'b1);
    wait_idle("t1_idle");
    chk("t1_nbursts", 64'(b_addr_q.size()), 64'd3);
    chk("t1_addr0", 64'(baddr(0)), 64'h1000_0000);
    chk("t1_addr1", 64'(baddr(1)), 64'h1000_0080);
    chk("t1_addr2", 64'(baddr(2)), 64'h1000_0100);
    chk("t1_bc0", 64'(bbc(0)), 64'd16);
    chk("t1_bc1", 64'(bbc(1)), 64'd16);
    chk("t1_bc2", 64'(bbc(2)), 64'd8);
    chk("t1_nwrites", 64'(wr_addr_q.size()), 64'd40);
    check_frame("t1_data", 0, 40, 32'h1000_0000, 32'hA1);
    chk("t1_ndone", 64'(d_idx_q.size()), 64'd1);
    chk("t1_words", 64'(dwords(0)), 64'd40);
    chk("t1_bufidx", 64'(didx(0)), 64'd0);
    clear_logs();

    // Ring of 3 buffers, 4 frames of 8 words
    start_run(32'h2000_0000, 32'h0010_0000, 3'd3, 8'd4);
    send_frame(8, 32'hB0, 1'b0, -1, 1'b1);
    send_frame(8, 32'hB1, 1'b0, -1, 1'b1);
    send_frame(8, 32'hB2, 1'b0, -1, 1'b1);
    send_frame(8, 32'hB3, 1'b0, -1, 1'b1);
    wait_idle("t2_idle");
    chk("t2_nbursts", 64'(b_addr_q.size()), 64'd4);
    chk("t2_addr0", 64'(baddr(0)), 64'h2000_0000);
    chk("t2_addr1", 64'(baddr(1)), 64'h2010_0000);
    chk("t2_addr2", 64'(baddr(2)), 64'h2020_0000);
    chk("t2_addr3_wrap", 64'(baddr(3)), 64'h2000_0000);
    chk("t2_ndone", 64'(d_idx_q.size()), 64'd4);
    chk("t2_idx0", 64'(didx(0)), 64'd0);
    chk("t2_idx1", 64'(didx(1)), 64'd1);
    chk("t2_idx2", 64'(didx(2)), 64'd2);
    chk("t2_idx3", 64'(didx(3)), 64'd0);
    check_frame("t2_data_f1", 8, 8, 32'h2010_0000, 32'hB1);
    clear_logs();

    // 1000-word frame with random stalls and source bubbles
    rand_wait = 1'b1;
    start_run(32'h3000_0000, 32'h0, 3'd1, 8'd1);
    send_frame(1000, 32'hC3, 1'b1, -1, 1'b1);
    wait_idle("t3_idle");
    rand_wait = 1'b0;
    chk("t3_nwrites", 64'(wr_addr_q.size()), 64'd1000);
    check_frame("t3_data", 0, 1000, 32'h3000_0000, 32'hC3);
    chk("t3_burst_stable", 64'(stable_err), 64'd0);
    chk("t3_words", 64'(dwords(0)), 64'd1000);
    clear_logs();

    // Continuous mode, stop during frame 3
    start_run(32'h4000_0000, 32'h0000_1000, 3'd2, 8'd0);
    send_frame(8, 32'hD1, 1'b0, -1, 1'b1);
    send_frame(8, 32'hD2, 1'b0, -1, 1'b1);
    send_frame(20, 32'hD3, 1'b0, 5, 1'b1);
    wait_idle("t4_idle");
    chk("t4_ndone", 64'(d_idx_q.size()), 64'd3);
    chk("t4_idx1", 64'(didx(1)), 64'd1);
    chk("t4_idx2", 64'(didx(2)), 64'd0);
    chk("t4_words2", 64'(dwords(2)), 64'd20);
    chk("t4_addr1", 64'(baddr(1)), 64'h4000_1000);
    check_frame("t4_data_f3", 16, 20, 32'h4000_0000, 32'hD3);
    rdy_any = 1'b0;
    din_valid = 1'b1; din_startofpacket = 1'b1; din_data = {32'hD4, 32'd0};
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      rdy_any |= din_ready;
      @(posedge clk); #1;
    end
    din_valid = 1'b0; din_startofpacket = 1'b0;
    chk("t4_late_sop_ready", 64'(rdy_any), 64'd0);
    chk("t4_late_sop_nwrites", 64'(wr_addr_q.size()), 64'd36);
    chk("t4_late_busy", 64'(sts_busy), 64'd0);
    clear_logs();

    // Non-sop beats in WAIT_SOP are discarded
    start_run(32'h5000_0000, 32'h0, 3'd1, 8'd1);
    rdy_all = 1'b1;
    for (int k = 0; k < 5; k++) begin
      din_valid = 1'b1; din_startofpacket = 1'b0; din_endofpacket = 1'b0;
      din_data = {32'hBAD0, 32'(k)};
      @(negedge clk);
      rdy_all &= din_ready;
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
    chk("t5_ready_discard", 64'(rdy_all), 64'd1);
    send_frame(4, 32'hE5, 1'b0, -1, 1'b1);
    wait_idle("t5_idle");
    chk("t5_nwrites", 64'(wr_addr_q.size()), 64'd4);
    check_frame("t5_data", 0, 4, 32'h5000_0000, 32'hE5);
    clear_logs();

    // Asynchronous reset in the middle of a burst
    start_run(32'h6000_0000, 32'h0, 3'd1, 8'd1);
    send_frame(20, 32'hF6, 1'b0, -1, 1'b0);
    g = 0;
    while (!avm_write && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    chk("t6_write_before_rst", 64'(avm_write), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_write", 64'(avm_write), 64'd0);
    chk("t6_rst_busy", 64'(sts_busy), 64'd0);
    chk("t6_rst_ready", 64'(din_ready), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_logs();
    start_run(32'h6000_0000, 32'h0, 3'd1, 8'd1);
    send_frame(8, 32'hF7, 1'b0, -1, 1'b1);
    wait_idle("t6_idle");
    chk("t6_restart_addr", 64'(baddr(0)), 64'h6000_0000);
    chk("t6_nwrites", 64'(wr_addr_q.size()), 64'd8);
    check_frame("t6_data", 0, 8, 32'h6000_0000, 32'hF7);
    chk("t6_words", 64'(dwords(0)), 64'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/image_store_burst_master.md
Name: image_store_burst_master

Overview:
- Next-generation image store writer: takes Avalon-ST video packets (one packet = one frame) and writes them to memory via a pipelined Avalon-MM burst master.
- Frames land in a ring of NUM_BUF buffers spaced FRAME_STRIDE bytes apart.
- Supports single-shot (N frames) and continuous modes, with per-frame completion status.
- Sits between the video pipeline output and the SDRAM/DDR arbiter.

Parameters:
- DATA_WIDTH, 64, stream and memory word width in bits; multiple of 8.
- FIFO_DEPTH_LOG, 8, log2 of internal FIFO depth in words.
- BURST_LEN_LOG, 4, log2 of maximum burst length; BURST_LEN_LOG < FIFO_DEPTH_LOG.
- BUF_CNT_W, 3, width of the buffer-count and buffer-index fields.
- FRAME_CNT_W, 8, width of the frame-count field.
- WORD_CNT_W, 24, width of the per-frame word counter.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- din_data  in  DATA_WIDTH  stream data.
- din_valid  in  1  stream valid.
- din_ready  out  1  stream ready.
- din_startofpacket  in  1  first word of frame.
- din_endofpacket  in  1  last word of frame.
- avm_address  out  32  byte address of the burst.
- avm_write  out  1  write request.
- avm_writedata  out  DATA_WIDTH  write data.
- avm_burstcount  out  BURST_LEN_LOG+1  beats in the burst.
- avm_waitrequest  in  1  slave stall.
- sig_en  in  1  start pulse; sampled only in IDLE.
- sig_stop  in  1  pulse: finish the current frame, then go to IDLE.
- sig_address  in  32  ring base address.
- sig_stride  in  32  byte distance between buffers.
- sig_buf_cnt  in  BUF_CNT_W  number of buffers in the ring; 0 is treated as 1.
- sig_frame_cnt  in  FRAME_CNT_W  frames to store; 0 = continuous.
- sts_busy  out  1  state != IDLE.
- sts_frame_done  out  1  one-cycle pulse per stored frame.
- sts_buf_idx  out  BUF_CNT_W  buffer holding the last completed frame.
- sts_frame_words  out  WORD_CNT_W  word count of the last completed frame.

Behaviour:
- Reset values:
  - avm_write=0, avm_burstcount=0, avm_address=0.
  - All sts_* = 0; din_ready=0.
  - FIFO empty; state=IDLE.
- Reset mid-burst: FIFO and state are cleared immediately; the partial burst is abandoned. This is accepted because reset is system-wide.
- Input FSM:
  - IDLE: sig_en latches base, stride, buf_cnt and frame_cnt, clears buf_idx, then → WAIT_SOP.
  - WAIT_SOP: sig_stop → IDLE. A beat with valid & sop → STREAM; that beat is written.
  - STREAM: valid & eop & ready → DRAIN.
  - DRAIN: waits until the FIFO is empty and the last burst is fully accepted, pulses sts_frame_done, then → NEXT.
  - NEXT: advances buf_idx, wrapping to 0 after buf_cnt-1. Decrements remaining frames when frame_cnt != 0. Goes to IDLE if the remaining count hits 0 or a stop is pending; otherwise → WAIT_SOP.
- sig_stop received in STREAM or DRAIN is held pending until NEXT.
- din_ready:
  - 1 in WAIT_SOP; non-sop beats there are consumed and discarded.
  - In STREAM, equals FIFO not full.
  - 0 in IDLE, DRAIN and NEXT.
- A sop arriving in STREAM is not treated specially: the frame continues.
- Word counter: increments per accepted STREAM beat and saturates at all-ones. It is copied to sts_frame_words on the frame_done cycle.
- Burst engine (independent of the input FSM):
  - Starts a burst when not bursting and either FIFO count >= BURST_LEN, or state==DRAIN with FIFO non-empty.
  - Latches avm_burstcount = min(count, BURST_LEN) and avm_address = base + buf_idx*stride + frame_offset.
  - The buf_idx*stride product is computed once at frame start; 32-bit arithmetic wraps modulo 2^32.
  - avm_write stays high for burstcount beats. Address and burstcount are held constant for the whole burst.
  - avm_writedata is the show-ahead FIFO head; a pop occurs on avm_write & ~avm_waitrequest.
  - After the last beat, frame_offset += burstcount*DATA_WIDTH/8.
  - avm_write drops for at least one cycle between bursts.
- frame_offset clears on entry to STREAM.
- sts_buf_idx updates on the frame_done cycle.
- Simultaneous FIFO push and pop: the count is unchanged.
- A full FIFO stalls the source only; no data is lost.
- sig_en outside IDLE is ignored.

Decomposition:
- Package image_store_pkg: state encodings (IDLE, WAIT_SOP, STREAM, DRAIN, NEXT) and a bytes-per-word function.
- Sub-module image_store_burst_fifo: single-clock show-ahead FIFO, parameter FIFO_DEPTH_LOG, outputs count, full and empty.
- The burst engine and FSM live in the top level.

Test Plan:
- DATA_WIDTH=64, BURST_LEN=16; sig_address=0x1000_0000, frame_cnt=1, 40-word frame, no waitrequest → bursts of 16, 16, 8 at 0x1000_0000, 0x1000_0080 and 0x1000_0100. Then one frame_done with sts_frame_words=40, buf_idx=0, busy→0.
- buf_cnt=3, stride=0x10_0000, frame_cnt=4, 8-word frames → first bursts at base+0, +0x10_0000, +0x20_0000, +0 (wrap). sts_buf_idx reads 0, 1, 2, 0.
- Random waitrequest at 50% plus input bubbles, 1000-word frame → memory contents equal the input sequence and burstcount is stable within each burst.
- frame_cnt=0 (continuous) and sig_stop pulsed mid-frame 3 → frame 3 completes, then IDLE. Exactly 3 frame_done pulses; a later sop is not written.
- 5 non-sop beats before the sop in WAIT_SOP → those beats are discarded, din_ready=1 throughout, and the first written word is the sop word.
- Async reset asserted mid-burst → avm_write=0 and sts_busy=0 immediately. A subsequent sig_en restarts cleanly at the base address.
